// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider.
package div_pkg;

    localparam int unsigned DIV_WIDTH = 32;
    localparam int unsigned CNT_W     = $clog2(DIV_WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_cond_neg.sv
// Combinational conditional two's-complement negate, modulo 2^WIDTH.
module div_cond_neg #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] in_i,
    input  logic             neg_i,
    output logic [WIDTH-1:0] out_o
);

    assign out_o = neg_i ? (~in_i + WIDTH'(1)) : in_i;

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider for DIV/DIVU, one quotient bit per cycle.
// Optional DIV_ZERO_DETECT_EN: short-circuits a zero divisor and reports it on div_zero_o.
module seq_divider
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             is_signed_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
`ifdef DIV_ZERO_DETECT_EN
    output logic             div_zero_o,
`endif
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    div_state_e       state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             sq_q, sq_d;
    logic             sr_q, sr_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef DIV_ZERO_DETECT_EN
    logic             div_zero_q, div_zero_d;
`endif

    logic             dvd_neg, dvs_neg;
    logic [WIDTH-1:0] mag_dvd, mag_dvs;
    logic [WIDTH-1:0] fix_quo, fix_rem;
    logic [WIDTH:0]   shifted, trial;

    assign dvd_neg = is_signed_i & dividend_i[WIDTH-1];
    assign dvs_neg = is_signed_i & divisor_i[WIDTH-1];

    div_cond_neg #(.WIDTH(WIDTH)) u_mag_dvd (.in_i(dividend_i), .neg_i(dvd_neg), .out_o(mag_dvd));
    div_cond_neg #(.WIDTH(WIDTH)) u_mag_dvs (.in_i(divisor_i),  .neg_i(dvs_neg), .out_o(mag_dvs));
    div_cond_neg #(.WIDTH(WIDTH)) u_fix_quo (.in_i(quo_q), .neg_i(sq_q), .out_o(fix_quo));
    div_cond_neg #(.WIDTH(WIDTH)) u_fix_rem (.in_i(rem_q[WIDTH-1:0]), .neg_i(sr_q), .out_o(fix_rem));

    // quo_q doubles as the dividend shift register: its MSB feeds the remainder each step.
    assign shifted = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    assign trial   = shifted - {1'b0, dvs_q};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        sq_d        = sq_q;
        sr_d        = sr_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
`ifdef DIV_ZERO_DETECT_EN
        div_zero_d  = div_zero_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    rem_d   = '0;
                    quo_d   = mag_dvd;
                    dvs_d   = mag_dvs;
                    sq_d    = dvd_neg ^ dvs_neg;
                    sr_d    = dvd_neg;
                    cnt_d   = CntW'(WIDTH);
                    busy_d  = 1'b1;
                    state_d = S_CALC;
`ifdef DIV_ZERO_DETECT_EN
                    div_zero_d = (divisor_i == '0);
                    // Sign-fixing |dividend| by sign(dividend) restores the raw dividend.
                    if (divisor_i == '0) begin
                        rem_d   = {1'b0, mag_dvd};
                        quo_d   = '1;
                        sq_d    = 1'b0;
                        state_d = S_DONE;
                    end
`endif
                end
            end
            S_CALC: begin
                quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
                rem_d = trial[WIDTH] ? shifted : trial;
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                quotient_d  = fix_quo;
                remainder_d = fix_rem;
                done_d      = 1'b1;
                busy_d      = 1'b0;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            sq_q        <= 1'b0;
            sr_q        <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
            div_zero_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            sq_q        <= sq_d;
            sr_q        <= sr_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef DIV_ZERO_DETECT_EN
            div_zero_q  <= div_zero_d;
`endif
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign quotient_o  = quotient_q;
    assign remainder_o = remainder_q;
`ifdef DIV_ZERO_DETECT_EN
    assign div_zero_o  = div_zero_q;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed corner cases plus random operands vs. a model.
module tb_seq_divider;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
`ifdef DIV_ZERO_DETECT_EN
    logic        div_zero;
`endif

    int n_checks = 0;
    int n_errors = 0;

    seq_divider #(.WIDTH(32)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .is_signed_i (is_signed),
        .dividend_i  (dividend),
        .divisor_i   (divisor),
        .busy_o      (busy),
        .done_o      (done),
`ifdef DIV_ZERO_DETECT_EN
        .div_zero_o  (div_zero),
`endif
        .quotient_o  (quotient),
        .remainder_o (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: divide magnitudes with plain arithmetic, then apply the sign rules.
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                                    output logic [31:0] q, output logic [31:0] r);
        logic [31:0] am;
        logic [31:0] bm;
        am = (sgn && a[31]) ? -a : a;
        bm = (sgn && b[31]) ? -b : b;
        if (bm == 0) begin
            q = 32'hFFFF_FFFF;
            r = am;
        end else begin
            q = am / bm;
            r = am % bm;
        end
        if (sgn && (a[31] ^ b[31])) q = -q;
        if (sgn && a[31]) r = -r;
`ifdef DIV_ZERO_DETECT_EN
        if (b == 0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end
`endif
    endfunction

    // Call at a negedge; returns at the negedge on which done was observed.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                          input int ign_at, input string tag);
        logic [31:0] eq;
        logic [31:0] er;
        int          lat_exp;
        int          lat;
        logic        busy_ok;
        ref_div(a, b, sgn, eq, er);
        lat_exp = 33;
`ifdef DIV_ZERO_DETECT_EN
        if (b == 0) lat_exp = 1;
`endif
        start     = 1'b1;
        dividend  = a;
        divisor   = b;
        is_signed = sgn;
        @(negedge clk);
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        check_eq({tag, ".busy_e0"}, 32'(busy), 32'd1);
        check_eq({tag, ".done_e0"}, 32'(done), 32'd0);
        lat     = 0;
        busy_ok = 1'b1;
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            if (k == ign_at) begin
                start     = 1'b1;
                dividend  = 32'd999;
                divisor   = 32'd3;
                is_signed = ~sgn;
            end
            @(negedge clk);
            start = 1'b0;
            if (done) lat = k;
            else if (!busy) busy_ok = 1'b0;
        end
        check_eq({tag, ".latency"}, 32'(lat), 32'(lat_exp));
        check_eq({tag, ".busy_held"}, 32'(busy_ok), 32'd1);
        check_eq({tag, ".busy_at_done"}, 32'(busy), 32'd0);
        check_eq({tag, ".quotient"}, quotient, eq);
        check_eq({tag, ".remainder"}, remainder, er);
`ifdef DIV_ZERO_DETECT_EN
        check_eq({tag, ".div_zero"}, 32'(div_zero), 32'(b == 0));
`endif
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic        s;

        rst_n     = 1'b0;
        start     = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        #12;
        check_eq("rst.busy", 32'(busy), 32'd0);
        check_eq("rst.done", 32'(done), 32'd0);
        check_eq("rst.quotient", quotient, 32'd0);
        check_eq("rst.remainder", remainder, 32'd0);
`ifdef DIV_ZERO_DETECT_EN
        check_eq("rst.div_zero", 32'(div_zero), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(32'd100, 32'd7, 1'b0, 0, "divu_100_7");
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 0, "div_m7_2");
        run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 0, "div_7_m2");
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, "div_ovf");
        @(negedge clk);
        check_eq("ovf.single_done", 32'(done), 32'd0);
        check_eq("ovf.held_q", quotient, 32'h8000_0000);
        run_op(32'h0000_1234, 32'd0, 1'b0, 0, "divu_zero");
        run_op(32'hFFFF_FFFB, 32'd0, 1'b1, 0, "div_zero_neg");
        run_op(32'd100, 32'd7, 1'b0, 10, "ignore_c10");
        run_op(32'd100, 32'd7, 1'b0, 33, "ignore_done");
        run_op(32'd55, 32'd5, 1'b0, 0, "back_to_back");

        // Abort mid-operation with asynchronous reset.
        start     = 1'b1;
        dividend  = 32'd1000;
        divisor   = 32'd9;
        is_signed = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("abort.busy", 32'(busy), 32'd0);
        check_eq("abort.done", 32'(done), 32'd0);
        check_eq("abort.quotient", quotient, 32'd0);
        check_eq("abort.remainder", remainder, 32'd0);
        begin
            int seen;
            seen = 0;
            for (int k = 0; k < 25; k++) begin
                if (k == 2) rst_n = 1'b1;
                @(negedge clk);
                if (done) seen++;
            end
            check_eq("abort.no_done", 32'(seen), 32'd0);
        end
        run_op(32'd1000, 32'd9, 1'b0, 0, "after_abort");

        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            b = $urandom;
            s = 1'($urandom_range(0, 1));
            case (i % 4)
                1: b = 32'($urandom_range(1, 15));
                2: b = b >> $urandom_range(0, 31);
                3: a = a >> $urandom_range(0, 31);
                default: ;
            endcase
            if (i == 7) b = 32'd0;
            run_op(a, b, s, 0, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
